// File: rtl/pll_ctrl_pkg.sv
// Shared definitions for the ECP5 PLL lock sequencer: state encoding,
// widths and a saturating retry-counter helper.
package pll_ctrl_pkg;

    localparam int STATE_W = 3;
    localparam int RETRY_W = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_RESET_PLL  = 3'd0,
        ST_WAIT_LOCK  = 3'd1,
        ST_STABLE     = 3'd2,
        ST_READY      = 3'd3,
        ST_FAIL       = 3'd4,
        ST_PHASE_STEP = 3'd5
    } state_t;

    function automatic logic [RETRY_W-1:0] retry_sat_inc(input logic [RETRY_W-1:0] v);
        return (v == {RETRY_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    // PHASE_STEP keeps ready high, so it counts as a ready state.
    function automatic logic is_ready_state(input state_t s);
        return (s == ST_READY) || (s == ST_PHASE_STEP);
    endfunction

endpackage

// File: rtl/pll_lock_ctrl_sync_1bit.sv
// Two-flop synchroniser bringing the asynchronous PLL lock into clk.
module sync_1bit (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/pll_lock_ctrl.sv
// EHXPLLL reset/lock sequencer with timeout, bounded retry and relock.
// Optional dynamic phase stepping when PLL_LOCK_CTRL_PHASE_STEP_EN is defined.
module pll_lock_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int MAX_RETRIES         = 3,
    parameter int PS_PULSE_CYCLES     = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pll_locked,
    input  logic               relock_req,
    output logic               pll_rst,
    output logic               sys_rst_req,
    output logic               ready,
    output logic               fail,
    output logic               lock_lost,
`ifdef PLL_LOCK_CTRL_PHASE_STEP_EN
    input  logic               ps_req,
    input  logic               ps_dir,
    output logic               ps_ack,
    output logic               pll_phasestep,
    output logic               pll_phasedir,
`endif
    output logic [RETRY_W-1:0] retry_count
);

    localparam int MAX_A  = (RST_PULSE_CYCLES > LOCK_STABLE_CYCLES) ? RST_PULSE_CYCLES : LOCK_STABLE_CYCLES;
    localparam int MAX_B  = (LOCK_TIMEOUT_CYCLES > 2 * PS_PULSE_CYCLES) ? LOCK_TIMEOUT_CYCLES : 2 * PS_PULSE_CYCLES;
    localparam int MAX_C  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W  = $clog2(MAX_C) + 1;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

    logic lock_s;

    sync_1bit u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (pll_locked),
        .q   (lock_s)
    );

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [RETRY_W-1:0] retry_reg, retry_next, retry_inc;
    logic               lock_lost_reg, lock_lost_next;
    logic               pll_rst_reg, sys_rst_req_reg, ready_reg, fail_reg;
    logic               lock_drop;

`ifdef PLL_LOCK_CTRL_PHASE_STEP_EN
    localparam logic [CNT_W-1:0] PS_HIGH_LAST = CNT_W'(PS_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] PS_LOW_LAST  = CNT_W'(2 * PS_PULSE_CYCLES - 1);

    logic phasestep_reg, phasestep_next;
    logic phasedir_reg, phasedir_next;
    logic ps_ack_reg, ps_ack_next;
`endif

    assign retry_inc = retry_sat_inc(retry_reg);
    assign lock_drop = is_ready_state(state_reg) && !lock_s;

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg + 1'b1;
        retry_next     = retry_reg;
        lock_lost_next = lock_lost_reg;
`ifdef PLL_LOCK_CTRL_PHASE_STEP_EN
        phasestep_next = phasestep_reg;
        phasedir_next  = phasedir_reg;
        ps_ack_next    = 1'b0;
`endif
        case (state_reg)
            ST_RESET_PLL: begin
                if (cnt_reg == RST_LAST) begin
                    state_next = ST_WAIT_LOCK;
                    cnt_next   = '0;
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_next = ST_STABLE;
                    cnt_next   = '0;
                end else if (cnt_reg == TIMEOUT_LAST) begin
                    retry_next = retry_inc;
                    state_next = (int'(retry_inc) > MAX_RETRIES) ? ST_FAIL : ST_RESET_PLL;
                    cnt_next   = '0;
                end
            end
            ST_STABLE: begin
                // A single dropout restarts the wait without charging a retry.
                if (!lock_s) begin
                    state_next = ST_WAIT_LOCK;
                    cnt_next   = '0;
                end else if (cnt_reg == STABLE_LAST) begin
                    state_next = ST_READY;
                    retry_next = '0;
                    cnt_next   = '0;
                end
            end
            ST_READY: begin
                cnt_next = '0;
                if (!lock_s) begin
                    lock_lost_next = 1'b1;
                    state_next     = ST_RESET_PLL;
                end else if (relock_req) begin
                    state_next = ST_RESET_PLL;
                end
`ifdef PLL_LOCK_CTRL_PHASE_STEP_EN
                else if (ps_req) begin
                    state_next     = ST_PHASE_STEP;
                    phasedir_next  = ps_dir;
                    phasestep_next = 1'b1;
                end
`endif
            end
            ST_FAIL: begin
                cnt_next = '0;
            end
`ifdef PLL_LOCK_CTRL_PHASE_STEP_EN
            ST_PHASE_STEP: begin
                if (!lock_s) begin
                    lock_lost_next = 1'b1;
                    phasestep_next = 1'b0;
                    state_next     = ST_RESET_PLL;
                    cnt_next       = '0;
                end else if (relock_req) begin
                    phasestep_next = 1'b0;
                    state_next     = ST_RESET_PLL;
                    cnt_next       = '0;
                end else if (cnt_reg == PS_HIGH_LAST) begin
                    phasestep_next = 1'b0;
                end else if (cnt_reg == PS_LOW_LAST) begin
                    ps_ack_next = 1'b1;
                    state_next  = ST_READY;
                    cnt_next    = '0;
                end
            end
`endif
            default: begin
                state_next = ST_RESET_PLL;
                cnt_next   = '0;
            end
        endcase

        // Relock overrides everything; a same-cycle lock loss still leaves lock_lost set.
        if (relock_req) begin
            state_next     = ST_RESET_PLL;
            cnt_next       = '0;
            retry_next     = '0;
            lock_lost_next = lock_drop;
`ifdef PLL_LOCK_CTRL_PHASE_STEP_EN
            phasestep_next = 1'b0;
            ps_ack_next    = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= ST_RESET_PLL;
            cnt_reg         <= '0;
            retry_reg       <= '0;
            lock_lost_reg   <= 1'b0;
            pll_rst_reg     <= 1'b1;
            sys_rst_req_reg <= 1'b1;
            ready_reg       <= 1'b0;
            fail_reg        <= 1'b0;
`ifdef PLL_LOCK_CTRL_PHASE_STEP_EN
            phasestep_reg   <= 1'b0;
            phasedir_reg    <= 1'b0;
            ps_ack_reg      <= 1'b0;
`endif
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            retry_reg       <= retry_next;
            lock_lost_reg   <= lock_lost_next;
            pll_rst_reg     <= (state_next == ST_RESET_PLL) || (state_next == ST_FAIL);
            sys_rst_req_reg <= !is_ready_state(state_next);
            ready_reg       <= is_ready_state(state_next);
            fail_reg        <= (state_next == ST_FAIL);
`ifdef PLL_LOCK_CTRL_PHASE_STEP_EN
            phasestep_reg   <= phasestep_next;
            phasedir_reg    <= phasedir_next;
            ps_ack_reg      <= ps_ack_next;
`endif
        end
    end

    assign pll_rst     = pll_rst_reg;
    assign sys_rst_req = sys_rst_req_reg;
    assign ready       = ready_reg;
    assign fail        = fail_reg;
    assign lock_lost   = lock_lost_reg;
    assign retry_count = retry_reg;
`ifdef PLL_LOCK_CTRL_PHASE_STEP_EN
    assign ps_ack        = ps_ack_reg;
    assign pll_phasestep = phasestep_reg;
    assign pll_phasedir  = phasedir_reg;
`endif

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Directed bench for pll_lock_ctrl; cycle numbers are counted from rst release.
// Phase-step checks run only when PLL_LOCK_CTRL_PHASE_STEP_EN is defined.
module tb_pll_lock_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       pll_locked;
    logic       relock_req;
    logic       pll_rst;
    logic       sys_rst_req;
    logic       ready;
    logic       fail;
    logic       lock_lost;
    logic [3:0] retry_count;
`ifdef PLL_LOCK_CTRL_PHASE_STEP_EN
    logic       ps_req;
    logic       ps_dir;
    logic       ps_ack;
    logic       pll_phasestep;
    logic       pll_phasedir;
`endif

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    pll_lock_ctrl #(
        .RST_PULSE_CYCLES    (4),
        .LOCK_STABLE_CYCLES  (8),
        .LOCK_TIMEOUT_CYCLES (32),
        .MAX_RETRIES         (3),
        .PS_PULSE_CYCLES     (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pll_locked    (pll_locked),
        .relock_req    (relock_req),
        .pll_rst       (pll_rst),
        .sys_rst_req   (sys_rst_req),
        .ready         (ready),
        .fail          (fail),
        .lock_lost     (lock_lost),
`ifdef PLL_LOCK_CTRL_PHASE_STEP_EN
        .ps_req        (ps_req),
        .ps_dir        (ps_dir),
        .ps_ack        (ps_ack),
        .pll_phasestep (pll_phasestep),
        .pll_phasedir  (pll_phasedir),
`endif
        .retry_count   (retry_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        $display("[TB] cyc=%0d %s observed=%0h expected=%0h", cyc, tag, obs, exp);
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s at cyc %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    initial begin
        rst        = 1'b1;
        pll_locked = 1'b0;
        relock_req = 1'b0;
`ifdef PLL_LOCK_CTRL_PHASE_STEP_EN
        ps_req     = 1'b0;
        ps_dir     = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_pll_rst",     32'(pll_rst), 32'd1);
        check("rst_sys_rst_req", 32'(sys_rst_req), 32'd1);
        check("rst_ready",       32'(ready), 32'd0);
        check("rst_fail",        32'(fail), 32'd0);
        check("rst_lock_lost",   32'(lock_lost), 32'd0);
        check("rst_retry",       32'(retry_count), 32'd0);

        // Nominal lock: pll_locked rises in cycle 10, ready at 21.
        rst = 1'b0;
        cyc = 0;
        check("nom_pll_rst_c0", 32'(pll_rst), 32'd1);
        run_to(3);  check("nom_pll_rst_c3", 32'(pll_rst), 32'd1);
        run_to(4);  check("nom_pll_rst_c4", 32'(pll_rst), 32'd0);
        run_to(10); pll_locked = 1'b1;
        run_to(20); check("nom_ready_c20", 32'(ready), 32'd0);
                    check("nom_srst_c20",  32'(sys_rst_req), 32'd1);
        run_to(21); check("nom_ready_c21", 32'(ready), 32'd1);
                    check("nom_srst_c21",  32'(sys_rst_req), 32'd0);
                    check("nom_retry_c21", 32'(retry_count), 32'd0);

        // Lock loss in READY: drop in 25, ready falls at 28, relock at 41.
        run_to(25); pll_locked = 1'b0;
        run_to(27); check("loss_ready_c27", 32'(ready), 32'd1);
        run_to(28); check("loss_ready_c28", 32'(ready), 32'd0);
                    check("loss_lost_c28",  32'(lock_lost), 32'd1);
                    check("loss_pllrst_c28", 32'(pll_rst), 32'd1);
        run_to(30); pll_locked = 1'b1;
        run_to(40); check("loss_ready_c40", 32'(ready), 32'd0);
        run_to(41); check("loss_ready_c41", 32'(ready), 32'd1);
                    check("loss_lost_c41",  32'(lock_lost), 32'd1);

        // Software relock from READY clears lock_lost.
        run_to(43); relock_req = 1'b1;
        tick();     relock_req = 1'b0;
        check("relock_ready_c44",  32'(ready), 32'd0);
        check("relock_pllrst_c44", 32'(pll_rst), 32'd1);
        check("relock_lost_c44",   32'(lock_lost), 32'd0);
        run_to(57); check("relock_ready_c57", 32'(ready), 32'd1);

        // Glitchy lock: loss at 60, lock high 70-74, low 75, high from 76.
        run_to(60); pll_locked = 1'b0;
        run_to(70); pll_locked = 1'b1;
        run_to(75); pll_locked = 1'b0;
        run_to(76); pll_locked = 1'b1;
        run_to(86); check("glitch_ready_c86", 32'(ready), 32'd0);
        run_to(87); check("glitch_ready_c87", 32'(ready), 32'd1);
                    check("glitch_retry_c87", 32'(retry_count), 32'd0);

        // Never lock: four timeouts, FAIL at 237.
        run_to(90);  pll_locked = 1'b0;
        run_to(128); check("never_pllrst_c128", 32'(pll_rst), 32'd0);
                     check("never_retry_c128",  32'(retry_count), 32'd0);
        run_to(129); check("never_pllrst_c129", 32'(pll_rst), 32'd1);
                     check("never_retry_c129",  32'(retry_count), 32'd1);
        run_to(165); check("never_retry_c165",  32'(retry_count), 32'd2);
        run_to(201); check("never_retry_c201",  32'(retry_count), 32'd3);
        run_to(236); check("never_fail_c236",   32'(fail), 32'd0);
        run_to(237); check("never_fail_c237",   32'(fail), 32'd1);
                     check("never_pllrst_c237", 32'(pll_rst), 32'd1);
                     check("never_retry_c237",  32'(retry_count), 32'd4);
                     check("never_srst_c237",   32'(sys_rst_req), 32'd1);
        run_to(250); check("never_fail_c250",   32'(fail), 32'd1);
        relock_req = 1'b1;
        tick();      relock_req = 1'b0;
        check("fail_relock_fail_c251",  32'(fail), 32'd0);
        check("fail_relock_retry_c251", 32'(retry_count), 32'd0);
        check("fail_relock_pllrst_c251", 32'(pll_rst), 32'd1);

        // Lock again, then assert rst asynchronously in READY.
        run_to(256); pll_locked = 1'b1;
        run_to(267); check("arst_ready_c267", 32'(ready), 32'd1);
        run_to(270);
        #2 rst = 1'b1;
        #1;
        check("arst_ready",   32'(ready), 32'd0);
        check("arst_srst",    32'(sys_rst_req), 32'd1);
        check("arst_pll_rst", 32'(pll_rst), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        run_to(12); check("arst_restart_ready_c12", 32'(ready), 32'd0);
        run_to(13); check("arst_restart_ready_c13", 32'(ready), 32'd1);

`ifdef PLL_LOCK_CTRL_PHASE_STEP_EN
        // Phase step with dir=1, then a second one aborted by lock loss.
        run_to(15); ps_req = 1'b1; ps_dir = 1'b1;
        tick();     ps_req = 1'b0; ps_dir = 1'b0;
        check("ps_step_c16",  32'(pll_phasestep), 32'd1);
        check("ps_dir_c16",   32'(pll_phasedir), 32'd1);
        check("ps_ready_c16", 32'(ready), 32'd1);
        run_to(19); check("ps_step_c19", 32'(pll_phasestep), 32'd1);
        run_to(20); check("ps_step_c20", 32'(pll_phasestep), 32'd0);
        run_to(23); check("ps_ack_c23",  32'(ps_ack), 32'd0);
        run_to(24); check("ps_ack_c24",  32'(ps_ack), 32'd1);
        run_to(25); check("ps_ack_c25",  32'(ps_ack), 32'd0);
                    check("ps_dir_c25",  32'(pll_phasedir), 32'd1);
        run_to(27); ps_req = 1'b1;
        tick();     ps_req = 1'b0;
        check("ps2_step_c28", 32'(pll_phasestep), 32'd1);
        check("ps2_dir_c28",  32'(pll_phasedir), 32'd0);
        pll_locked = 1'b0;
        run_to(30); check("ps2_step_c30",  32'(pll_phasestep), 32'd1);
        run_to(31); check("ps2_step_c31",  32'(pll_phasestep), 32'd0);
                    check("ps2_pllrst_c31", 32'(pll_rst), 32'd1);
                    check("ps2_ready_c31", 32'(ready), 32'd0);
        run_to(36); check("ps2_ack_c36",   32'(ps_ack), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
